wide_add_seq: RTL and testbench

//   Sequencer that time-shares one FastAdder_16 (16-bit carry-lookahead adder) to do

---
 rtl/wide_add_pkg.sv | 12 +
 rtl/wide_add_seq_fastadder.sv | 60 ++++++
 rtl/wide_add_seq.sv | 123 ++++++++++++
 tb/tb_wide_add_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared limb width and sequencer state type for the wide add/subtract unit.
package wide_add_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } wide_add_state_t;

endpackage

// File: rtl/wide_add_seq_fastadder.sv
// FastAdder_16: purely combinational 16-bit adder, four 4-bit lookahead groups
// with a second lookahead level across the groups.
module FastAdder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic [15:0] ci;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    // Group carries come straight from cin, so no carry ripples between groups.
    always_comb begin
        gc    = '0;
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cin);
    end

    always_comb begin
        ci = '0;
        for (int k = 0; k < 4; k++) begin
            ci[4*k]   = gc[k];
            ci[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            ci[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            ci[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    end

    assign sum  = p ^ ci;
    assign cout = gc[4];

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: WORDS*16-bit add/subtract done one limb per cycle on a single
// shared FastAdder_16, with the inter-limb carry held in a register.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    ovf
);

    localparam int W     = LIMB_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    wide_add_state_t state;
    wide_add_state_t state_next;

    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      a_shift;
    logic [W-1:0]      b_shift;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic [LIMB_W-1:0] limb_a;
    logic [LIMB_W-1:0] limb_b;
    logic [LIMB_W-1:0] limb_sum;
    logic              limb_cout;
    logic              last_limb;
    logic              accept;

    assign a_shift   = a_reg >> (LIMB_W * idx);
    assign b_shift   = b_reg >> (LIMB_W * idx);
    assign limb_a    = a_shift[LIMB_W-1:0];
    assign limb_b    = b_shift[LIMB_W-1:0];
    assign last_limb = (idx == IDX_W'(WORDS - 1));

    FastAdder_16 u_adder (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (carry),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_limb) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on capture and the +1 enters as the first carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= op_sub ? ~b : b;
            carry <= op_sub;
            idx   <= '0;
        end else if (state == S_RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx == IDX_W'(i)) begin
                    sum[LIMB_W*i +: LIMB_W] <= limb_sum;
                end
            end
            carry <= limb_cout;
            if (last_limb) begin
                cout <= limb_cout;
                ovf  <= (limb_a[LIMB_W-1] == limb_b[LIMB_W-1]) &&
                        (limb_sum[LIMB_W-1] != limb_a[LIMB_W-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: a 4-limb and a 1-limb instance checked
// against fixed vectors, hand-built corner sequences and an arithmetic reference.
module tb_wide_add_seq;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid4, in_ready4, op_sub4, out_valid4, out_ready4, cout4, ovf4;
    logic [63:0] a4, b4, sum4;
    logic        in_valid1, in_ready1, op_sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [15:0] a1, b1, sum1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          words;
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    wide_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op_sub(op_sub4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    wide_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op_sub(op_sub1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // Reference: plain unsigned arithmetic on the masked operands, overflow from operand/result signs.
    function automatic void refModel(input int words, input logic sub, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] s,
                                     output logic c, output logic o);
        int          w;
        logic [64:0] mask, ea, eb, full;
        logic        sa, sb, ss;
        w    = 16 * words;
        mask = (65'd1 << w) - 65'd1;
        ea   = {1'b0, a} & mask;
        eb   = {1'b0, b} & mask;
        if (sub) begin
            full = (ea - eb) & mask;
            c    = (ea >= eb);
        end else begin
            full = ea + eb;
            c    = full[w];
        end
        s  = full[63:0] & mask[63:0];
        sa = ea[w-1];
        sb = eb[w-1];
        ss = full[w-1];
        o  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int words);
        return (words == 4) ? in_ready4 : in_ready1;
    endfunction

    function automatic logic vld(input int words);
        return (words == 4) ? out_valid4 : out_valid1;
    endfunction

    task automatic driveReq(input int words, input logic sub, input logic [63:0] a,
                            input logic [63:0] b);
        if (words == 4) begin
            in_valid4 = 1'b1; op_sub4 = sub; a4 = a; b4 = b;
        end else begin
            in_valid1 = 1'b1; op_sub1 = sub; a1 = a[15:0]; b1 = b[15:0];
        end
    endtask

    task automatic dropReq(input int words);
        if (words == 4) in_valid4 = 1'b0;
        else            in_valid1 = 1'b0;
    endtask

    task automatic setOutReady(input int words, input logic v);
        if (words == 4) out_ready4 = v;
        else            out_ready1 = v;
    endtask

    // Accept the request, then count edges until out_valid (bounded).
    task automatic applyStimulus(input int words, input logic sub, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] s,
                                 output logic c, output logic o, output int lat);
        int guard;
        guard = 0;
        driveReq(words, sub, a, b);
        while (!rdy(words) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rdy(words)) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept timeout: in_ready 0, expected 1");
        end
        @(posedge clk); #1;
        dropReq(words);
        lat = 0;
        while (!vld(words) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        s = (words == 4) ? sum4 : {48'h0, sum1};
        c = (words == 4) ? cout4 : cout1;
        o = (words == 4) ? ovf4 : ovf1;
    endtask

    task automatic releaseResult(input int words);
        setOutReady(words, 1'b1);
        @(posedge clk); #1;
        setOutReady(words, 1'b0);
    endtask

    initial begin
        logic [63:0] s, es, ra, rb;
        logic        c, o, ec, eo, rs;
        int          lat, words;

        in_valid4 = 0; op_sub4 = 0; a4 = '0; b4 = '0; out_ready4 = 0;
        in_valid1 = 0; op_sub1 = 0; a1 = '0; b1 = '0; out_ready1 = 0;
        rst = 1'b1;

        vecs.push_back('{words:4, sub:0, a:64'h0000_0000_0000_FFFF, b:64'h1,
                         exp_sum:64'h0000_0000_0001_0000, exp_cout:0, exp_ovf:0});
        vecs.push_back('{words:4, sub:0, a:64'hFFFF_FFFF_FFFF_FFFF, b:64'h1,
                         exp_sum:64'h0, exp_cout:1, exp_ovf:0});
        vecs.push_back('{words:4, sub:1, a:64'h0, b:64'h1,
                         exp_sum:64'hFFFF_FFFF_FFFF_FFFF, exp_cout:0, exp_ovf:0});
        vecs.push_back('{words:4, sub:1, a:64'h5, b:64'h5, exp_sum:64'h0, exp_cout:1, exp_ovf:0});
        vecs.push_back('{words:4, sub:0, a:64'h7FFF_FFFF_FFFF_FFFF, b:64'h1,
                         exp_sum:64'h8000_0000_0000_0000, exp_cout:0, exp_ovf:1});
        vecs.push_back('{words:4, sub:1, a:64'h8000_0000_0000_0000, b:64'h1,
                         exp_sum:64'h7FFF_FFFF_FFFF_FFFF, exp_cout:1, exp_ovf:1});
        vecs.push_back('{words:1, sub:0, a:64'hFFFF, b:64'h1, exp_sum:64'h0, exp_cout:1, exp_ovf:0});
        vecs.push_back('{words:1, sub:1, a:64'h0, b:64'h1, exp_sum:64'hFFFF, exp_cout:0, exp_ovf:0});
        vecs.push_back('{words:1, sub:1, a:64'h5, b:64'h5, exp_sum:64'h0, exp_cout:1, exp_ovf:0});
        vecs.push_back('{words:1, sub:0, a:64'h7FFF, b:64'h1, exp_sum:64'h8000, exp_cout:0, exp_ovf:1});
        vecs.push_back('{words:1, sub:1, a:64'h8000, b:64'h1, exp_sum:64'h7FFF, exp_cout:1, exp_ovf:1});
        vecs.push_back('{words:1, sub:0, a:64'h1234, b:64'h4321, exp_sum:64'h5555, exp_cout:0, exp_ovf:0});

        @(posedge clk); #1;
        checkOutput("reset in_ready4", {63'h0, in_ready4}, 64'h1);
        checkOutput("reset out_valid4", {63'h0, out_valid4}, 64'h0);
        checkOutput("reset sum4", sum4, 64'h0);
        checkOutput("reset cout4", {63'h0, cout4}, 64'h0);
        checkOutput("reset ovf4", {63'h0, ovf4}, 64'h0);
        checkOutput("reset in_ready1", {63'h0, in_ready1}, 64'h1);
        checkOutput("reset out_valid1", {63'h0, out_valid1}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].words, vecs[i].sub, vecs[i].a, vecs[i].b, s, c, o, lat);
            checkOutput($sformatf("vec%0d sum", i), s, vecs[i].exp_sum);
            checkOutput($sformatf("vec%0d cout", i), {63'h0, c}, {63'h0, vecs[i].exp_cout});
            checkOutput($sformatf("vec%0d ovf", i), {63'h0, o}, {63'h0, vecs[i].exp_ovf});
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].words));
            releaseResult(vecs[i].words);
            checkOutput($sformatf("vec%0d ready after release", i),
                        {63'h0, rdy(vecs[i].words)}, 64'h1);
        end

        $display("[TB] backpressure in DONE");
        refModel(4, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, es, ec, eo);
        applyStimulus(4, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, s, c, o, lat);
        driveReq(4, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1111_2222_3333_4444);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d sum", k), sum4, es);
            checkOutput($sformatf("hold%0d cout", k), {63'h0, cout4}, {63'h0, ec});
            checkOutput($sformatf("hold%0d ovf", k), {63'h0, ovf4}, {63'h0, eo});
            checkOutput($sformatf("hold%0d out_valid", k), {63'h0, out_valid4}, 64'h1);
            checkOutput($sformatf("hold%0d in_ready", k), {63'h0, in_ready4}, 64'h0);
        end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        dropReq(4);
        out_ready4 = 1'b0;
        checkOutput("release in_ready", {63'h0, in_ready4}, 64'h1);
        checkOutput("release out_valid", {63'h0, out_valid4}, 64'h0);

        $display("[TB] reset mid-run");
        driveReq(4, 1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
        @(posedge clk); #1;
        dropReq(4);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("midrun rst out_valid", {63'h0, out_valid4}, 64'h0);
        checkOutput("midrun rst in_ready", {63'h0, in_ready4}, 64'h1);
        checkOutput("midrun rst sum", sum4, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("discarded op out_valid", {63'h0, out_valid4}, 64'h0);
        applyStimulus(4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, s, c, o, lat);
        checkOutput("post-rst sum", s, 64'h0);
        checkOutput("post-rst cout", {63'h0, c}, 64'h1);
        checkOutput("post-rst ovf", {63'h0, o}, 64'h0);
        checkOutput("post-rst latency", 64'(lat), 64'd4);
        releaseResult(4);

        $display("[TB] random operations");
        for (int i = 0; i < 60; i++) begin
            words = (i % 3 == 0) ? 1 : 4;
            rs    = 1'($urandom % 2);
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            case ($urandom % 5)
                0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
                1: rb = 64'h8000_0000_0000_8000;
                2: rb = ra;
                default: ;
            endcase
            refModel(words, rs, ra, rb, es, ec, eo);
            applyStimulus(words, rs, ra, rb, s, c, o, lat);
            checkOutput($sformatf("rnd%0d sum", i), s, es);
            checkOutput($sformatf("rnd%0d cout", i), {63'h0, c}, {63'h0, ec});
            checkOutput($sformatf("rnd%0d ovf", i), {63'h0, o}, {63'h0, eo});
            checkOutput($sformatf("rnd%0d latency", i), 64'(lat), 64'(words));
            releaseResult(words);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
